fft_peak_finder: RTL and testbench

- Downstream consumer of the FFT state machine's result memory. It runs once after the FFT reports Done.
- Reads bins FIRST_BIN..LAST_BIN through a registered read port and computes squared magnitude re²+im² for each bin.
- Reports the bin with the largest magnitude and that magnitude. The tuner uses this as the coarse pitch estimate.
- Flags the peak as valid only if its magnitude reaches a programmable threshold.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_mag_sq.sv | 82 ++++++++
 rtl/fft_peak_finder.sv | 210 +++++++++++++++++++++
 tb/tb_fft_peak_finder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT result consumers.
//   - default sample / address / magnitude widths
//   - default scanned bin range (skips DC, stops at N/2-1)
//   - one-hot state encoding of the peak finder controller
package fft_pkg;

  localparam int FFT_DATA_W    = 32;
  localparam int FFT_ADDR_W    = 8;
  localparam int FFT_MAG_W     = 2 * FFT_DATA_W + 1;
  localparam int FFT_FIRST_BIN = 1;
  localparam int FFT_LAST_BIN  = 127;

  // One-hot, same style as the FFT controller.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SCAN  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } pf_state_e;

endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: two-stage registered squared-magnitude pipeline.
//   Stage 1 registers re^2 and im^2 (2*DATA_W bits each, unsigned),
//   stage 2 registers their sum at 2*DATA_W+1 bits so it can never wrap.
//   A valid bit and a bin tag travel alongside the data.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_bin       sample present this cycle and its bin index
//   in_re/in_im           signed sample
//   s1_valid              stage-1 occupancy (used to detect an empty pipe)
//   out_valid/out_bin     stage-2 result present and its bin index
//   out_mag               re^2 + im^2
module fft_mag_sq
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int ADDR_W = FFT_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [ADDR_W-1:0]   in_bin,
  input  logic [DATA_W-1:0]   in_re,
  input  logic [DATA_W-1:0]   in_im,
  output logic                s1_valid,
  output logic                out_valid,
  output logic [ADDR_W-1:0]   out_bin,
  output logic [2*DATA_W:0]   out_mag
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int MAG_W  = 2 * DATA_W + 1;

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_bin_q, s1_bin_d;
  logic [PROD_W-1:0] p_re_q, p_re_d;
  logic [PROD_W-1:0] p_im_q, p_im_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] s2_bin_q, s2_bin_d;
  logic [MAG_W-1:0]  s2_mag_q, s2_mag_d;
  logic [PROD_W-1:0] re_ext, im_ext;

  // Next values for both stages; squares of sign-extended operands are exact
  // in the low 2*DATA_W bits because |x|^2 <= 2^(2*DATA_W-2).
  always_comb begin
    re_ext     = {{DATA_W{in_re[DATA_W-1]}}, in_re};
    im_ext     = {{DATA_W{in_im[DATA_W-1]}}, in_im};
    s1_valid_d = in_valid;
    s1_bin_d   = in_bin;
    p_re_d     = re_ext * re_ext;
    p_im_d     = im_ext * im_ext;
    s2_valid_d = s1_valid_q;
    s2_bin_d   = s1_bin_q;
    s2_mag_d   = {1'b0, p_re_q} + {1'b0, p_im_q};
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= {ADDR_W{1'b0}};
      p_re_q     <= {PROD_W{1'b0}};
      p_im_q     <= {PROD_W{1'b0}};
      s2_valid_q <= 1'b0;
      s2_bin_q   <= {ADDR_W{1'b0}};
      s2_mag_q   <= {MAG_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_bin_q   <= s1_bin_d;
      p_re_q     <= p_re_d;
      p_im_q     <= p_im_d;
      s2_valid_q <= s2_valid_d;
      s2_bin_q   <= s2_bin_d;
      s2_mag_q   <= s2_mag_d;
    end
  end

  assign s1_valid  = s1_valid_q;
  assign out_valid = s2_valid_q;
  assign out_bin   = s2_bin_q;
  assign out_mag   = s2_mag_q;

endmodule

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: scans FFT result bins FIRST_BIN..LAST_BIN once per Start,
// finds the bin with the largest re^2+im^2 and flags it valid when the
// magnitude reaches the threshold latched at Start.
// Ports:
//   Clk, Reset_n          clock, synchronous active-low reset
//   Start, MinMag         scan request and threshold (sampled together)
//   RdEn, RdAddr          result memory read request (registered port)
//   RdRe, RdIm            read data, valid one cycle after RdEn
//   PeakBin, PeakMag      result, loaded on the edge Done rises
//   PeakValid             PeakMag >= latched MinMag
//   Ready, Busy, Done     IDLE / SCAN or DRAIN / DONE status, mutually exclusive
module fft_peak_finder
  import fft_pkg::*;
#(
  parameter int DATA_W    = FFT_DATA_W,
  parameter int ADDR_W    = FFT_ADDR_W,
  parameter int FIRST_BIN = FFT_FIRST_BIN,
  parameter int LAST_BIN  = FFT_LAST_BIN
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic [2*DATA_W:0]   MinMag,
  output logic                RdEn,
  output logic [ADDR_W-1:0]   RdAddr,
  input  logic [DATA_W-1:0]   RdRe,
  input  logic [DATA_W-1:0]   RdIm,
  output logic [ADDR_W-1:0]   PeakBin,
  output logic [2*DATA_W:0]   PeakMag,
  output logic                PeakValid,
  output logic                Ready,
  output logic                Busy,
  output logic                Done
);

  localparam int MAG_W = 2 * DATA_W + 1;
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_BIN);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_BIN);

  pf_state_e         state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_bin_q, pend_bin_d;
  logic [MAG_W-1:0]  min_mag_q, min_mag_d;
  logic [MAG_W-1:0]  max_q, max_d;
  logic [ADDR_W-1:0] max_bin_q, max_bin_d;
  logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0]  peak_mag_q, peak_mag_d;
  logic              peak_valid_q, peak_valid_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_ok;
  logic              drain_done;
  logic              sq_s1_valid;
  logic              sq_valid;
  logic [ADDR_W-1:0] sq_bin;
  logic [MAG_W-1:0]  sq_mag;

  // Data for the bin addressed last cycle is on RdRe/RdIm now: pend_q tags it.
  fft_mag_sq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mag_sq (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .in_valid  (pend_q),
    .in_bin    (pend_bin_q),
    .in_re     (RdRe),
    .in_im     (RdIm),
    .s1_valid  (sq_s1_valid),
    .out_valid (sq_valid),
    .out_bin   (sq_bin),
    .out_mag   (sq_mag)
  );

  // Start is only honoured when not busy.
  assign start_ok   = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Last sum is being compared this cycle and nothing else is in flight.
  assign drain_done = sq_valid && !sq_s1_valid && !pend_q;

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_SCAN;
        else          state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (rd_addr_q == LAST_A) state_d = ST_DRAIN;
        else                     state_d = ST_SCAN;
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_DONE;
        else            state_d = ST_DRAIN;
      end
      ST_DONE: begin
        if (start_ok) state_d = ST_SCAN;
        else          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values, all registered below.
  always_comb begin
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    pend_d       = rd_en_q;
    pend_bin_d   = rd_addr_q;
    min_mag_d    = min_mag_q;
    max_d        = max_q;
    max_bin_d    = max_bin_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_valid_d = peak_valid_q;

    if (state_d == ST_SCAN) begin
      rd_en_d = 1'b1;
      if (state_q == ST_SCAN) rd_addr_d = rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      else                    rd_addr_d = FIRST_A;
    end else begin
      rd_en_d = 1'b0;
    end

    // Running max: cleared on Start; strict compare keeps the lowest bin on
    // ties, and an all-zero spectrum leaves the bin at FIRST_BIN.
    if (start_ok) begin
      min_mag_d = MinMag;
      max_d     = {MAG_W{1'b0}};
      max_bin_d = FIRST_A;
    end else if (sq_valid && (sq_mag > max_q)) begin
      max_d     = sq_mag;
      max_bin_d = sq_bin;
    end else begin
      max_d     = max_q;
      max_bin_d = max_bin_q;
    end

    // Result includes the final compare, published on the edge Done rises.
    if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
      peak_bin_d   = max_bin_d;
      peak_mag_d   = max_d;
      peak_valid_d = (max_d >= min_mag_q);
    end else begin
      peak_bin_d   = peak_bin_q;
      peak_mag_d   = peak_mag_q;
      peak_valid_d = peak_valid_q;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_SCAN) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  // Output and datapath registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_en_q      <= 1'b0;
      rd_addr_q    <= {ADDR_W{1'b0}};
      pend_q       <= 1'b0;
      pend_bin_q   <= {ADDR_W{1'b0}};
      min_mag_q    <= {MAG_W{1'b0}};
      max_q        <= {MAG_W{1'b0}};
      max_bin_q    <= {ADDR_W{1'b0}};
      peak_bin_q   <= {ADDR_W{1'b0}};
      peak_mag_q   <= {MAG_W{1'b0}};
      peak_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      pend_q       <= pend_d;
      pend_bin_q   <= pend_bin_d;
      min_mag_q    <= min_mag_d;
      max_q        <= max_d;
      max_bin_q    <= max_bin_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_valid_q <= peak_valid_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign RdEn      = rd_en_q;
  assign RdAddr    = rd_addr_q;
  assign PeakBin   = peak_bin_q;
  assign PeakMag   = peak_mag_q;
  assign PeakValid = peak_valid_q;
  assign Ready     = ready_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Bench for fft_peak_finder: registered-read memory model, table of scan
// vectors with a result scoreboard, plus reset / restart / mid-scan corners.
module tb_fft_peak_finder;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [64:0] MinMag = 65'd0;
  logic        RdEn;
  logic [7:0]  RdAddr;
  logic [31:0] RdRe = 32'd0;
  logic [31:0] RdIm = 32'd0;
  logic [7:0]  PeakBin;
  logic [64:0] PeakMag;
  logic        PeakValid, Ready, Busy, Done;

  fft_peak_finder dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .MinMag(MinMag),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdRe(RdRe), .RdIm(RdIm),
    .PeakBin(PeakBin), .PeakMag(PeakMag), .PeakValid(PeakValid),
    .Ready(Ready), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem_re [256];
  logic [31:0] mem_im [256];
  int cyc = 0;
  int dc_hits = 0;
  int onehot_bad = 0;
  logic mon_on = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  // Registered-read result memory.
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (RdEn) begin
      RdRe <= mem_re[RdAddr];
      RdIm <= mem_im[RdAddr];
      if (RdAddr == 8'd0) dc_hits <= dc_hits + 1;
    end
  end

  // Status outputs must be one-hot after reset.
  always @(negedge Clk) begin
    if (mon_on && ((int'(Ready) + int'(Busy) + int'(Done)) != 1)) onehot_bad <= onehot_bad + 1;
  end

  typedef struct {
    string       name;
    int          kind;      // 0 zero, 1 tone17, 2 tie, 3 extremes
    logic [64:0] min_mag;
    int          exp_bin;
    logic [64:0] exp_mag;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    string       name;
    int          bin;
    logic [64:0] mag;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < 256; i++) begin
      mem_re[i] = 32'd0;
      mem_im[i] = 32'd0;
    end
    case (kind)
      1: begin
        mem_re[17] = 32'd1000;
        mem_im[17] = -32'sd2000;
      end
      2: begin
        mem_re[40] = 32'd300; mem_im[40] = 32'd400;
        mem_re[90] = 32'd300; mem_im[90] = 32'd400;
      end
      3: begin
        for (int i = 1; i < 256; i++) mem_re[i] = 32'd1;
        mem_re[127] = 32'h8000_0000;
        mem_im[127] = 32'h8000_0000;
        mem_re[0]   = 32'h4000_0000;
      end
      default: ;
    endcase
  endtask

  // Runs one scan; optionally pulses Start again mid-scan and checks the
  // restart-from-DONE behaviour against the previous result.
  task automatic run_scan(input string name, input logic [64:0] mm, input int exp_bin,
                          input logic [64:0] exp_mag, input logic exp_valid,
                          input int extra_start_at, input logic chk_restart, input int prev_bin);
    exp_t e;
    int t0;
    int lat;
    logic got;
    e.name = name; e.bin = exp_bin; e.mag = exp_mag; e.valid = exp_valid;
    @(negedge Clk);
    Start  = 1'b1;
    MinMag = mm;
    sb.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
    t0 = cyc;
    if (chk_restart) begin
      check({name, "_restart_done_low"}, {64'd0, Done}, 65'd0);
      check({name, "_restart_bin_kept"}, {57'd0, PeakBin}, 65'(prev_bin));
    end
    got = 1'b0;
    for (int i = 1; i < 400; i++) begin
      @(negedge Clk);
      Start = (i == extra_start_at);
      if (Done) begin
        got = 1'b1;
        break;
      end
    end
    Start = 1'b0;
    lat = cyc - t0;
    check({name, "_done_seen"}, {64'd0, got}, 65'd1);
    check({name, "_latency"}, 65'(lat), 65'd130);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 65'd0, 65'd1);
    end else begin
      e = sb.pop_front();
      check({e.name, "_bin"}, {57'd0, PeakBin}, 65'(e.bin));
      check({e.name, "_mag"}, PeakMag, e.mag);
      check({e.name, "_valid"}, {64'd0, PeakValid}, {64'd0, e.valid});
    end
    repeat (3) @(negedge Clk);
    check({name, "_hold_done"}, {64'd0, Done}, 65'd1);
    check({name, "_hold_bin"}, {57'd0, PeakBin}, 65'(exp_bin));
  endtask

  initial begin
    logic [64:0] big;
    big = 65'd1 << 63;
    vecs[0] = '{"tone_thr_eq",  1, 65'd5000000, 17, 65'd5000000, 1'b1};
    vecs[1] = '{"tone_thr_gt",  1, 65'd5000001, 17, 65'd5000000, 1'b0};
    vecs[2] = '{"tie",          2, 65'd0,       40, 65'd250000,  1'b1};
    vecs[3] = '{"extremes",     3, big,        127, big,         1'b1};
    vecs[4] = '{"zero_thr0",    0, 65'd0,        1, 65'd0,       1'b1};
    vecs[5] = '{"zero_thr1",    0, 65'd1,        1, 65'd0,       1'b0};

    // Power-on reset.
    fill(0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    mon_on = 1'b1;
    check("rst_ready", {64'd0, Ready}, 65'd1);
    check("rst_busy",  {64'd0, Busy},  65'd0);
    check("rst_done",  {64'd0, Done},  65'd0);
    check("rst_rden",  {64'd0, RdEn},  65'd0);
    check("rst_addr",  {57'd0, RdAddr}, 65'd0);
    check("rst_pbin",  {57'd0, PeakBin}, 65'd0);
    check("rst_pmag",  PeakMag, 65'd0);
    check("rst_pval",  {64'd0, PeakValid}, 65'd0);

    // Table-driven scans; each after the first restarts from DONE.
    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].kind);
      run_scan(vecs[v].name, vecs[v].min_mag, vecs[v].exp_bin, vecs[v].exp_mag,
               vecs[v].exp_valid, 0, (v != 0), (v == 0) ? 0 : vecs[v-1].exp_bin);
    end

    // Start mid-scan is ignored; latency still counts from the first Start.
    fill(2);
    run_scan("mid_start", 65'd0, 40, 65'd250000, 1'b1, 60, 1'b1, 1);

    // Reset held 3 cycles mid-scan aborts the scan.
    fill(1);
    @(negedge Clk);
    Start = 1'b1;
    MinMag = 65'd0;
    @(negedge Clk);
    Start = 1'b0;
    repeat (50) @(negedge Clk);
    mon_on = 1'b0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    mon_on = 1'b1;
    check("mrst_ready", {64'd0, Ready}, 65'd1);
    check("mrst_busy",  {64'd0, Busy},  65'd0);
    check("mrst_done",  {64'd0, Done},  65'd0);
    check("mrst_rden",  {64'd0, RdEn},  65'd0);
    check("mrst_addr",  {57'd0, RdAddr}, 65'd0);
    check("mrst_pbin",  {57'd0, PeakBin}, 65'd0);
    check("mrst_pmag",  PeakMag, 65'd0);
    check("mrst_pval",  {64'd0, PeakValid}, 65'd0);
    repeat (5) @(negedge Clk);
    check("mrst_idle_stays", {64'd0, Ready}, 65'd1);
    run_scan("after_rst", 65'd5000000, 17, 65'd5000000, 1'b1, 0, 1'b0, 0);

    check("dc_never_read", 65'(dc_hits), 65'd0);
    check("status_onehot", 65'(onehot_bad), 65'd0);
    check("sb_drained", 65'(sb.size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
